// File: rtl/receiver_protocol.sv
// Single-wire frame receiver: start bit 1, DATA_W payload bits LSB first, stop bit 0.
// The received payload is held on a valid/ready interface; framing errors and overruns pulse for one cycle.
module receiver_protocol #(
   parameter int DATA_W = 55,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              S_Data,
   output logic [DATA_W-1:0] RX_Data,
   output logic              RX_Data_Valid,
   input  logic              RX_Ready,
   output logic              Frame_Err,
   output logic              Overrun
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_t              state_r, state_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic [DATA_W-1:0]   shift_r, shift_s;
   logic [DATA_W-1:0]   rx_data_r, rx_data_s;
   logic                rx_valid_r, rx_valid_s;
   logic                frame_err_r, frame_err_s;
   logic                overrun_r, overrun_s;

   // Next-state, datapath and output-register update logic.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      shift_s     = shift_r;
      rx_data_s   = rx_data_r;
      // A held payload is released when the consumer takes it at this edge.
      rx_valid_s  = rx_valid_r & ~RX_Ready;
      frame_err_s = 1'b0;
      overrun_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (S_Data) begin
               state_s = DATA;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = IDLE;
            end
         end
         DATA: begin
            shift_s[cnt_r] = S_Data;
            if (cnt_r == LAST_CNT) begin
               state_s = STOP;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         STOP: begin
            state_s = IDLE;
            if (S_Data) begin
               frame_err_s = 1'b1;
            end else if (!rx_valid_r || RX_Ready) begin
               // Holding register is free (or being emptied now): load without a bubble.
               rx_data_s  = shift_r;
               rx_valid_s = 1'b1;
            end else begin
               overrun_s = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         shift_r     <= {DATA_W{1'b0}};
         rx_data_r   <= {DATA_W{1'b0}};
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         shift_r     <= shift_s;
         rx_data_r   <= rx_data_s;
         rx_valid_r  <= rx_valid_s;
         frame_err_r <= frame_err_s;
         overrun_r   <= overrun_s;
      end
   end

   assign RX_Data       = rx_data_r;
   assign RX_Data_Valid = rx_valid_r;
   assign Frame_Err     = frame_err_r;
   assign Overrun       = overrun_r;

endmodule

// File: tb/tb_receiver_protocol.sv
// Scenario-driven bench for receiver_protocol: expected payloads are queued when a
// good frame is driven and popped when the receiver presents it.
module tb_receiver_protocol;
   localparam int DW = 55;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          S_Data = 1'b0;
   logic          RX_Ready = 1'b1;
   logic [DW-1:0] RX_Data;
   logic          RX_Data_Valid;
   logic          Frame_Err;
   logic          Overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   int vcnt = 0;
   int cyc = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_d;

   receiver_protocol #(.DATA_W(DW), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .S_Data(S_Data),
      .RX_Data(RX_Data), .RX_Data_Valid(RX_Data_Valid), .RX_Ready(RX_Ready),
      .Frame_Err(Frame_Err), .Overrun(Overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse and valid-cycle counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (Frame_Err) ferr_cnt <= ferr_cnt + 1;
      if (Overrun) ovr_cnt <= ovr_cnt + 1;
      if (RX_Data_Valid) vcnt <= vcnt + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      S_Data = 1'b0;
      repeat (n) tick();
   endtask

   // Start bit plus payload; the caller drives the stop bit.
   task automatic send_payload(input logic [DW-1:0] d);
      S_Data = 1'b1;
      tick();
      for (int i = 0; i < DW; i++) begin
         S_Data = d[i];
         tick();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; S_Data = 1'b0; RX_Ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_cmp++; if (RX_Data_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", RX_Data_Valid); end
      n_cmp++; if (RX_Data !== 55'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", RX_Data); end
      n_cmp++; if (Frame_Err !== 1'b0 || Overrun !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got %b%b want 00", Frame_Err, Overrun); end
   endtask

   task automatic test_single;
      int e_f, e_o;
      e_f = ferr_cnt; e_o = ovr_cnt;
      RX_Ready = 1'b1;
      idle(5);
      send_payload(55'h12_3456_789A_BCDE);
      n_cmp++; if (RX_Data_Valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", RX_Data_Valid); end
      exp_q.push_back(55'h12_3456_789A_BCDE);
      S_Data = 1'b0; tick();
      exp_d = exp_q.pop_front();
      n_cmp++; if (RX_Data_Valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", RX_Data_Valid); end
      n_cmp++; if (RX_Data !== exp_d) begin n_bad++; $display("FAIL single_data: got %h want %h", RX_Data, exp_d); end
      tick();
      n_cmp++; if (RX_Data_Valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_clear: got %b want 0", RX_Data_Valid); end
      tick();
      n_cmp++; if (ferr_cnt !== e_f || ovr_cnt !== e_o) begin n_bad++; $display("FAIL single_errs: got %0d/%0d want %0d/%0d", ferr_cnt, ovr_cnt, e_f, e_o); end
   endtask

   task automatic test_back_to_back;
      int c1, c2, e_f, e_o, e_v;
      e_f = ferr_cnt; e_o = ovr_cnt; e_v = vcnt;
      RX_Ready = 1'b1;
      send_payload(55'h0);
      exp_q.push_back(55'h0);
      S_Data = 1'b0; tick();
      c1 = cyc;
      exp_d = exp_q.pop_front();
      n_cmp++; if (RX_Data_Valid !== 1'b1 || RX_Data !== exp_d) begin n_bad++; $display("FAIL b2b_first: got %b/%h want 1/%h", RX_Data_Valid, RX_Data, exp_d); end
      send_payload(55'h7F_FFFF_FFFF_FFFF);
      exp_q.push_back(55'h7F_FFFF_FFFF_FFFF);
      S_Data = 1'b0; tick();
      c2 = cyc;
      exp_d = exp_q.pop_front();
      n_cmp++; if (RX_Data_Valid !== 1'b1 || RX_Data !== exp_d) begin n_bad++; $display("FAIL b2b_second: got %b/%h want 1/%h", RX_Data_Valid, RX_Data, exp_d); end
      n_cmp++; if (c2 - c1 !== 57) begin n_bad++; $display("FAIL b2b_gap: got %0d want 57", c2 - c1); end
      idle(2);
      n_cmp++; if (vcnt - e_v !== 2) begin n_bad++; $display("FAIL b2b_valid_cycles: got %0d want 2", vcnt - e_v); end
      n_cmp++; if (ferr_cnt !== e_f || ovr_cnt !== e_o) begin n_bad++; $display("FAIL b2b_errs: got %0d/%0d want %0d/%0d", ferr_cnt, ovr_cnt, e_f, e_o); end
   endtask

   task automatic test_overrun;
      int e_o;
      RX_Ready = 1'b0;
      send_payload(55'h1);
      exp_q.push_back(55'h1);
      S_Data = 1'b0; tick();
      exp_d = exp_q.pop_front();
      n_cmp++; if (RX_Data_Valid !== 1'b1 || RX_Data !== exp_d) begin n_bad++; $display("FAIL ovr_first: got %b/%h want 1/%h", RX_Data_Valid, RX_Data, exp_d); end
      idle(3);
      e_o = ovr_cnt;
      send_payload(55'h2);
      S_Data = 1'b0; tick();
      n_cmp++; if (Overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_pulse: got %b want 1", Overrun); end
      tick();
      n_cmp++; if (Overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_pulse_end: got %b want 0", Overrun); end
      n_cmp++; if (ovr_cnt - e_o !== 1) begin n_bad++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt - e_o); end
      n_cmp++; if (RX_Data_Valid !== 1'b1 || RX_Data !== 55'h1) begin n_bad++; $display("FAIL ovr_held: got %b/%h want 1/1", RX_Data_Valid, RX_Data); end
      RX_Ready = 1'b1; tick();
      n_cmp++; if (RX_Data_Valid !== 1'b0) begin n_bad++; $display("FAIL ovr_accept: got %b want 0", RX_Data_Valid); end
   endtask

   task automatic test_accept_and_load;
      int e_o;
      RX_Ready = 1'b0;
      send_payload(55'h0A_AAAA_0000_1111);
      exp_q.push_back(55'h0A_AAAA_0000_1111);
      S_Data = 1'b0; tick();
      exp_d = exp_q.pop_front();
      n_cmp++; if (RX_Data_Valid !== 1'b1 || RX_Data !== exp_d) begin n_bad++; $display("FAIL sim_a: got %b/%h want 1/%h", RX_Data_Valid, RX_Data, exp_d); end
      e_o = ovr_cnt;
      send_payload(55'h33_0F0F_1234_5678);
      exp_q.push_back(55'h33_0F0F_1234_5678);
      S_Data = 1'b0; RX_Ready = 1'b1; tick();
      exp_d = exp_q.pop_front();
      n_cmp++; if (RX_Data_Valid !== 1'b1 || RX_Data !== exp_d) begin n_bad++; $display("FAIL sim_b: got %b/%h want 1/%h", RX_Data_Valid, RX_Data, exp_d); end
      n_cmp++; if (Overrun !== 1'b0) begin n_bad++; $display("FAIL sim_no_ovr: got %b want 0", Overrun); end
      tick();
      n_cmp++; if (RX_Data_Valid !== 1'b0) begin n_bad++; $display("FAIL sim_clear: got %b want 0", RX_Data_Valid); end
      n_cmp++; if (ovr_cnt !== e_o) begin n_bad++; $display("FAIL sim_ovr_count: got %0d want %0d", ovr_cnt, e_o); end
   endtask

   task automatic test_frame_err;
      int e_f, e_v;
      RX_Ready = 1'b1;
      e_f = ferr_cnt; e_v = vcnt;
      send_payload(55'h15_0000_ABCD_0001);
      S_Data = 1'b1; tick();
      n_cmp++; if (Frame_Err !== 1'b1 || RX_Data_Valid !== 1'b0) begin n_bad++; $display("FAIL ferr_pulse: got %b/%b want 1/0", Frame_Err, RX_Data_Valid); end
      idle(1);
      n_cmp++; if (Frame_Err !== 1'b0) begin n_bad++; $display("FAIL ferr_pulse_end: got %b want 0", Frame_Err); end
      idle(2);
      n_cmp++; if (ferr_cnt - e_f !== 1 || vcnt !== e_v) begin n_bad++; $display("FAIL ferr_counts: got %0d/%0d want 1/0", ferr_cnt - e_f, vcnt - e_v); end
      send_payload(55'h55_5555_5555_5555);
      exp_q.push_back(55'h55_5555_5555_5555);
      S_Data = 1'b0; tick();
      exp_d = exp_q.pop_front();
      n_cmp++; if (RX_Data_Valid !== 1'b1 || RX_Data !== exp_d) begin n_bad++; $display("FAIL ferr_next: got %b/%h want 1/%h", RX_Data_Valid, RX_Data, exp_d); end
      idle(2);
   endtask

   task automatic test_reset_mid;
      logic [DW-1:0] d;
      int e_v, e_f, e_o;
      d = 55'h0F_FFFF;
      RX_Ready = 1'b0;
      send_payload(55'h3C_C3C3_5A5A_A5A5);
      exp_q.push_back(55'h3C_C3C3_5A5A_A5A5);
      S_Data = 1'b0; tick();
      exp_d = exp_q.pop_front();
      n_cmp++; if (RX_Data_Valid !== 1'b1 || RX_Data !== exp_d) begin n_bad++; $display("FAIL rmid_held: got %b/%h want 1/%h", RX_Data_Valid, RX_Data, exp_d); end
      idle(2);
      S_Data = 1'b1; tick();
      for (int i = 0; i < 20; i++) begin S_Data = d[i]; tick(); end
      rst = 1'b1; S_Data = d[20]; tick();
      rst = 1'b0;
      n_cmp++; if (RX_Data_Valid !== 1'b0 || RX_Data !== 55'h0) begin n_bad++; $display("FAIL rmid_clear: got %b/%h want 0/0", RX_Data_Valid, RX_Data); end
      n_cmp++; if (Frame_Err !== 1'b0 || Overrun !== 1'b0) begin n_bad++; $display("FAIL rmid_flags: got %b%b want 00", Frame_Err, Overrun); end
      tick();
      e_v = vcnt; e_f = ferr_cnt; e_o = ovr_cnt;
      for (int i = 22; i < DW; i++) begin S_Data = d[i]; tick(); end
      idle(61);
      n_cmp++; if (vcnt !== e_v || ferr_cnt !== e_f || ovr_cnt !== e_o) begin n_bad++; $display("FAIL rmid_quiet: got %0d/%0d/%0d want 0/0/0", vcnt - e_v, ferr_cnt - e_f, ovr_cnt - e_o); end
      RX_Ready = 1'b1;
      send_payload(55'h2A_1357_9BDF_0246);
      exp_q.push_back(55'h2A_1357_9BDF_0246);
      S_Data = 1'b0; tick();
      exp_d = exp_q.pop_front();
      n_cmp++; if (RX_Data_Valid !== 1'b1 || RX_Data !== exp_d) begin n_bad++; $display("FAIL rmid_fresh: got %b/%h want 1/%h", RX_Data_Valid, RX_Data, exp_d); end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_accept_and_load();
      test_frame_err();
      test_reset_mid();
      n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
